// File: rtl/mux_pkg.sv
// Shared definitions for the streaming mux family: mode encoding and the
// index-width helper used to size channel selects.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n channels, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority search: grants the first requester at or after ptr,
// wrapping at N-1. Purely combinational; ptr must be below N.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    int idx;

    // Walk offsets from the far end so the nearest requester writes last.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt_idx = SW'(idx);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel streaming mux with fixed-select or round-robin arbitration and a
// one-deep registered output. Optional out_chan tag: define MUX_CHAN_TAG_EN.
module mux_stream_rr
    import mux_pkg::*;
#(
    parameter int  N  = 4,
    parameter int  W  = 4,
    localparam int SW = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data
`ifdef MUX_CHAN_TAG_EN
    ,
    output logic [SW-1:0]  out_chan
`endif
);

    // Handshake: a word moves on channel i when in_valid[i] & in_ready[i]
    // at a rising edge; the output word is consumed when out_valid &
    // out_ready. in_ready depends only on the register state, mode and sel
    // (plus in_valid in round-robin mode), never on in_data.

    localparam logic [SW:0]   N_EXT  = (SW + 1)'(N);
    localparam logic [SW-1:0] LAST_I = SW'(N - 1);

    logic          load;
    logic          xfer;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] ptr_next;
    logic [SW-1:0] arb_idx;
    logic          arb_any;
    logic [SW-1:0] gnt_idx;
    logic          gnt_any;
    logic          gnt_valid;
    logic [W-1:0]  gnt_data;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign load = !out_valid || out_ready;

    // Fixed mode grants sel even when that channel is idle.
    always_comb begin
        gnt_idx = arb_idx;
        gnt_any = arb_any;
        if (mode == MODE_FIXED) begin
            gnt_idx = sel;
            gnt_any = ({1'b0, sel} < N_EXT);
        end
    end

    always_comb begin
        in_ready  = '0;
        gnt_data  = '0;
        gnt_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SW'(i)) begin
                gnt_data  = in_data[i*W +: W];
                gnt_valid = in_valid[i];
                in_ready[i] = load && gnt_any && !rst;
            end
        end
    end

    assign xfer     = load && gnt_any && gnt_valid;
    assign ptr_next = (gnt_idx == LAST_I) ? '0 : gnt_idx + SW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer && mode == MODE_RR) begin
            rr_ptr <= ptr_next;
        end
    end

    // An empty load slot drops out_valid but keeps the last data word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= gnt_data;
            end
        end
    end

`ifdef MUX_CHAN_TAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_chan <= '0;
        end else if (xfer) begin
            out_chan <= gnt_idx;
        end
    end
`endif

endmodule

// File: tb/tb_mux_stream_rr.sv
// Bench for mux_stream_rr (N=4, W=4): directed vector table, reset sequence,
// and randomized traffic against a spec-level reference model.
module tb_mux_stream_rr;
    import mux_pkg::*;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SW = 2;

    logic           clk;
    logic           rst;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;

    mux_stream_rr #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef MUX_CHAN_TAG_EN
        ,
        .out_chan  (out_chan)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic         m_ov;
    logic [W-1:0] m_od;
    int           m_ch;
    int           m_ptr;

    typedef struct {
        logic           mode;
        logic [SW-1:0]  sel;
        logic [N-1:0]   valid;
        logic [N*W-1:0] data;
        logic           ordy;
        logic [N-1:0]   e_rdy;
        logic           e_ov;
        logic [W-1:0]   e_od;
        logic [SW-1:0]  e_ch;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ov  = 1'b0;
        m_od  = '0;
        m_ch  = 0;
        m_ptr = 0;
    endtask

    // Grant per the rules: fixed uses sel, RR picks the first valid from ptr.
    function automatic int model_grant(input logic md, input logic [SW-1:0] s,
                                       input logic [N-1:0] v);
        if (md == MODE_FIXED) begin
            return (int'(s) < N) ? int'(s) : -1;
        end
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        logic load;
        load = !m_ov || out_ready;
        g = model_grant(mode, sel, in_valid);
        if (!load || g < 0) return '0;
        return N'(1) << g;
    endfunction

    task automatic model_clock();
        int g;
        logic load;
        load = !m_ov || out_ready;
        g = model_grant(mode, sel, in_valid);
        if (load) begin
            if (g >= 0 && in_valid[g]) begin
                m_ov = 1'b1;
                m_od = in_data[g*W +: W];
                m_ch = g;
                if (mode == MODE_RR) m_ptr = (g + 1) % N;
            end else begin
                m_ov = 1'b0;
            end
        end
    endtask

    // One cycle: drive at negedge, check ready, clock, check registered outputs.
    task automatic step(input logic md, input logic [SW-1:0] s, input logic [N-1:0] v,
                        input logic [N*W-1:0] d, input logic ordy);
        mode      = md;
        sel       = s;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        check("in_ready_model", 32'(in_ready), 32'(model_ready()));
        @(posedge clk);
        model_clock();
        #1;
        check("out_valid_model", 32'(out_valid), 32'(m_ov));
        if (m_ov) check("out_data_model", 32'(out_data), 32'(m_od));
`ifdef MUX_CHAN_TAG_EN
        if (m_ov) check("out_chan_model", 32'(out_chan), 32'(m_ch));
`endif
        @(negedge clk);
    endtask

    initial begin
        // {mode, sel, valid, data, ordy, e_rdy, e_ov, e_od, e_ch}
        vecs[0]  = '{MODE_FIXED, 2'd2, 4'b1111, 16'h4C21, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2};
        vecs[1]  = '{MODE_FIXED, 2'd1, 4'b1101, 16'h4C21, 1'b1, 4'b0010, 1'b0, 4'hC, 2'd2};
        vecs[2]  = '{MODE_RR,    2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        vecs[3]  = '{MODE_RR,    2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
        vecs[4]  = '{MODE_RR,    2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2};
        vecs[5]  = '{MODE_RR,    2'd0, 4'b1111, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3};
        vecs[6]  = '{MODE_RR,    2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        vecs[7]  = '{MODE_RR,    2'd0, 4'b1010, 16'h8021, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
        vecs[8]  = '{MODE_RR,    2'd0, 4'b1010, 16'h8021, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
        vecs[9]  = '{MODE_RR,    2'd0, 4'b1010, 16'h8021, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
        vecs[10] = '{MODE_RR,    2'd0, 4'b1010, 16'h8021, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
        vecs[11] = '{MODE_RR,    2'd0, 4'b1010, 16'h8021, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
        vecs[12] = '{MODE_RR,    2'd0, 4'b1010, 16'h8021, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
        vecs[13] = '{MODE_RR,    2'd0, 4'b1010, 16'h8021, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
        vecs[14] = '{MODE_RR,    2'd0, 4'b1010, 16'h8021, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
        vecs[15] = '{MODE_RR,    2'd0, 4'b0000, 16'h8021, 1'b1, 4'b0000, 1'b0, 4'h2, 2'd1};

        // Reset and idle
        rst       = 1'b1;
        mode      = MODE_FIXED;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        in_data   = 16'h4321;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
`ifdef MUX_CHAN_TAG_EN
        check("reset_out_chan", 32'(out_chan), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            mode      = vecs[i].mode;
            sel       = vecs[i].sel;
            in_valid  = vecs[i].valid;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            model_clock();
            #1;
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
`ifdef MUX_CHAN_TAG_EN
            check($sformatf("vec%0d_out_chan", i), 32'(out_chan), 32'(vecs[i].e_ch));
`endif
            @(negedge clk);
        end

        // Reset mid-stream: load a word, hold it with backpressure, reset.
        step(MODE_RR, 2'd0, 4'b0100, 16'h0500, 1'b1);
        step(MODE_RR, 2'd0, 4'b0000, 16'h0000, 1'b0);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // Pointer restarted at 0: with all channels valid, ch0 wins.
        mode = MODE_RR;
        #1;
        check("postrst_rr_grant", 32'(in_ready), 32'b0001);
        step(MODE_RR, 2'd0, 4'b1111, 16'h4321, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), SW'($urandom_range(0, N - 1)),
                 N'($urandom_range(0, (1 << N) - 1)), (N*W)'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
- Parametrised N-channel, W-bit streaming multiplexer with a valid/ready handshake on every channel and a registered output stage.
- Two modes:
  - Fixed-select: a `sel` input chooses the channel.
  - Round-robin: the block scans all channels fairly.
- Successor to the combinational 4:1 4-bit mux. Sits between multiple producer streams and one consumer.

Parameters:
- N, 4, number of input channels (2..16)
- W, 4, data width per channel (1..64)
- SW, $clog2(N) (min 1), select/channel-index width (derived, localparam)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SW  channel index used in fixed mode
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready (combinational)
- in_data  in  N*W  packed inputs; channel i = in_data[i*W +: W]
- out_valid  out  1  output register holds data
- out_ready  in  1  consumer accepts
- out_data  out  W  registered selected data
- out_chan  out  SW  source channel of out_data (only with MUX_CHAN_TAG_EN)

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. in_ready=0 while rst=1.
- Load enable: load = !out_valid | out_ready. Output register is one deep; no skid buffer.
- Grant g:
  - Fixed mode: g = sel. No grant if sel >= N.
  - RR mode: g = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N. No grant if no valid.
- in_ready[i] = load & granted & (i==g). At most one bit set. Fixed mode asserts in_ready[sel] even if in_valid[sel]=0.
- Transfer on channel g when in_valid[g] & in_ready[g]. Next edge:
  - out_data <= in_data[g]
  - out_valid <= 1
  - out_chan <= g
  - RR mode only: rr_ptr <= (g==N-1) ? 0 : g+1
- If load=1 and no transfer: out_valid <= 0; out_data holds last value.
- If load=0 (out_valid & !out_ready): all registers hold and in_ready=0.
- Latency: input accepted at edge k is visible at out_* after edge k. Throughput is 1 word/cycle when out_ready=1.
- rr_ptr holds in fixed mode. Mode or sel changes apply combinationally in the same cycle; a word already in the register is not affected.
- Simultaneous consume and accept (out_valid & out_ready & new transfer): out_valid stays 1 and the new data replaces the old in one edge. No bubble.
- Reset mid-stream: the pending output word is discarded; arbitration restarts at channel 0.
- Non-power-of-2 N: the pointer wraps at N-1, not at 2^SW-1.

Optional Feature:
- Macro MUX_CHAN_TAG_EN.
- Defined: out_chan port exists and is registered with out_data; reset value 0.
- Undefined: out_chan port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1
  - function clog2_min1(n)
- One sub-module, rr_arbiter:
  - Inputs: req[N], ptr[SW]
  - Outputs: gnt_idx[SW], gnt_any
  - Purely combinational rotate-priority search; reusable by later N-channel blocks.
- Top module: mode select, handshake, output register, pointer update.

Test Plan:
- Reset and idle. Assert rst mid-transfer while out_valid=1 -> out_valid=0, out_data=0, in_ready=0 immediately; after release, rr_ptr=0.
- Fixed mode, N=4, W=4. sel=2, in_data ch2=4'b1100, all valid, out_ready=1 -> in_ready=4'b0100; out_data=4'b1100 one cycle later; out_chan=2.
- Fixed mode, sel=1, in_valid[1]=0 -> no transfer; out_valid drops to 0 next cycle; in_ready[1]=1 and other in_ready bits 0.
- RR mode, all four channels valid with data 1,2,3,4, out_ready=1 -> outputs 1,2,3,4,1,... on consecutive cycles with no gaps; grant order 0,1,2,3,0.
- RR mode, only ch1 and ch3 valid, ch3 data=4'b1000 -> output alternates ch1, ch3. Check rr_ptr wraps from 3 to 0, and ch1 is chosen even though rr_ptr=0 with ch0 idle.
- Backpressure. out_valid=1, out_ready=0 for 3 cycles -> out_data stable and in_ready=0. Then out_ready=1 with a new valid input -> replacement in the same cycle and out_valid stays 1.
